nibble_ones_accumulator: RTL

Serial-to-nibble ones-counting stage that packs an incoming 1-bit stream into 4-bit nibbles and counts the set bits in each nibble. It reports each nibble's count, and accumulates the counts over a frame of FRAME_NIBBLES nibbles into a frame total. It delivers that total through a valid/ready handshake. It sits directly around the 4-input ones-count logic: it gathers the four input bits for that logic and consumes its 3-bit result.

---
 rtl/nibble_ones_accumulator_pkg.sv | 15 +
 rtl/nibble_ones_accumulator_popcount4.sv | 18 +
 rtl/nibble_ones_accumulator.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/nibble_ones_accumulator_pkg.sv
// nibble_pkg: shared types and constants for the nibble ones-counting stage.
//   state_e : frame FSM states (COLLECT gathers bits, DONE holds the total)
//   NIB_W   : nibble width in bits
//   CNT_W   : width of a per-nibble ones count (0..4)
package nibble_pkg;

   localparam int unsigned NIB_W = 4;
   localparam int unsigned CNT_W = 3;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } state_e;

endpackage

// File: rtl/nibble_ones_accumulator_popcount4.sv
// popcount4: purely combinational ones count of a 4-bit nibble.
//   nib   : input nibble
//   count : number of set bits in nib (0..4)
module popcount4
   import nibble_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   output logic [CNT_W-1:0] count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < NIB_W; i++) begin
         count = count + CNT_W'(nib[i]);
      end
   end

endmodule

// File: rtl/nibble_ones_accumulator.sv
// nibble_ones_accumulator: packs a serial bit stream into nibbles (first bit
// at bit 3), reports each nibble with its ones count, and accumulates the
// counts over FRAME_NIBBLES nibbles into a frame total offered on a
// valid/ready handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous abort of the current frame
//   in_bit/in_valid       : serial input, accepted when in_ready is high
//   in_ready              : high while collecting (state only)
//   nib_valid             : one-cycle pulse marking new nib_data/nib_count
//   nib_data, nib_count   : last completed nibble and its ones count
//   out_valid/out_ready   : frame total handshake
//   total                 : ones in the completed frame
module nibble_ones_accumulator
   import nibble_pkg::*;
#(
   parameter int unsigned FRAME_NIBBLES = 8,
   parameter int unsigned SUM_W         = $clog2(4*FRAME_NIBBLES+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             nib_valid,
   output logic [NIB_W-1:0] nib_data,
   output logic [CNT_W-1:0] nib_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] total
);

   localparam int unsigned      IDX_W    = (FRAME_NIBBLES > 1) ? $clog2(FRAME_NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_NIBBLES - 1);

   state_e             state_q,     state_d;
   // Only the three most recent bits are ever read: the fourth arrives
   // as in_bit in the completing cycle, so the shift register stops at 3.
   logic [NIB_W-2:0]   shift_q,     shift_d;
   logic [1:0]         bit_cnt_q,   bit_cnt_d;
   logic [IDX_W-1:0]   nib_idx_q,   nib_idx_d;
   logic [SUM_W-1:0]   acc_q,       acc_d;
   logic [SUM_W-1:0]   total_q,     total_d;
   logic               nib_valid_q, nib_valid_d;
   logic [NIB_W-1:0]   nib_data_q,  nib_data_d;
   logic [CNT_W-1:0]   nib_count_q, nib_count_d;

   logic [NIB_W-1:0]   nib_next;
   logic [CNT_W-1:0]   pop_count;
   logic               accept;

   assign nib_next = {shift_q, in_bit};

   popcount4 u_popcount4 (
      .nib   (nib_next),
      .count (pop_count)
   );

   assign in_ready  = (state_q == COLLECT);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;

   assign nib_valid = nib_valid_q;
   assign nib_data  = nib_data_q;
   assign nib_count = nib_count_q;
   assign total     = total_q;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      nib_idx_d   = nib_idx_q;
      acc_d       = acc_q;
      total_d     = total_q;
      nib_valid_d = 1'b0;
      nib_data_d  = nib_data_q;
      nib_count_d = nib_count_q;

      if (clear) begin
         state_d   = COLLECT;
         shift_d   = '0;
         bit_cnt_d = '0;
         nib_idx_d = '0;
         acc_d     = '0;
         total_d   = '0;
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (accept) begin
                  shift_d   = nib_next[NIB_W-2:0];
                  bit_cnt_d = bit_cnt_q + 2'd1;
                  if (bit_cnt_q == 2'd3) begin
                     nib_data_d  = nib_next;
                     nib_count_d = pop_count;
                     nib_valid_d = 1'b1;
                     if (nib_idx_q == LAST_IDX) begin
                        total_d   = acc_q + SUM_W'(pop_count);
                        acc_d     = '0;
                        nib_idx_d = '0;
                        state_d   = DONE;
                     end else begin
                        acc_d     = acc_q + SUM_W'(pop_count);
                        nib_idx_d = nib_idx_q + IDX_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = COLLECT;
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         nib_idx_q   <= '0;
         acc_q       <= '0;
         total_q     <= '0;
         nib_valid_q <= 1'b0;
         nib_data_q  <= '0;
         nib_count_q <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         nib_idx_q   <= nib_idx_d;
         acc_q       <= acc_d;
         total_q     <= total_d;
         nib_valid_q <= nib_valid_d;
         nib_data_q  <= nib_data_d;
         nib_count_q <= nib_count_d;
      end
   end

endmodule
